// File: rtl/multi_port_mem_ctrl_if.sv
// Consumer-side request/response bundle for multi_port_mem_ctrl.
// Each per-port field is packed side by side, with port 0 in the low bits.
interface multi_port_mem_ctrl_if #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_PORTS-1:0]            dispatch_read;
   logic [NUM_PORTS-1:0]            dispatch_write;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] write_data;
   logic [NUM_PORTS*DATA_WIDTH-1:0] read_data;
   logic [NUM_PORTS-1:0]            finished_op;

   modport master (
      output dispatch_read, dispatch_write, addr, write_data,
      input  read_data, finished_op
   );

   modport slave (
      input  dispatch_read, dispatch_write, addr, write_data,
      output read_data, finished_op
   );
endinterface

// File: rtl/multi_port_mem_ctrl.sv
// Round-robin arbiter that shares one RAM, one write-only frame buffer and one IO bus
// among NUM_PORTS consumers, serving one access at a time.
module multi_port_mem_ctrl #(
   parameter int                     NUM_PORTS   = 2,
   parameter int                     ADDR_WIDTH  = 32,
   parameter int                     DATA_WIDTH  = 8,
   parameter int                     RAM_LATENCY = 2,
   parameter logic [ADDR_WIDTH-9:0]  IO_PREFIX   = 24'hFFFFFF,
   parameter logic [ADDR_WIDTH-17:0] FB_PREFIX   = 16'h0000
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   multi_port_mem_ctrl_if.slave  cpu,
   output logic [15:0]           ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [15:0]           fb_write_addr,
   output logic [DATA_WIDTH-1:0] fb_write_data,
   output logic                  fb_write_enable,
   output logic [7:0]            io_addr,
   output logic [DATA_WIDTH-1:0] io_wdata,
   output logic                  io_we,
   output logic                  io_re,
   input  logic [DATA_WIDTH-1:0] io_rdata,
   input  logic                  io_ready
);
   // state      | meaning
   // S_IDLE     | arbitrate; latch the granted port's request
   // S_ISSUE    | strobe RAM/FB writes, start RAM reads, route IO
   // S_WAIT_RAM | count down RAM_LATENCY, then capture ram_dout
   // S_WAIT_IO  | hold io_re/io_we until io_ready
   // S_DONE     | finished_op pulse for the granted port

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RAM,
      S_WAIT_IO,
      S_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]              grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
   logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
   logic                          we_q, we_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [NUM_PORTS-1:0]          finished_op_q, finished_op_d;
   logic [NUM_PORTS*DATA_WIDTH-1:0] read_data_q, read_data_d;

   logic [NUM_PORTS-1:0]          req;
   logic                          gnt_valid;
   logic [PTR_W-1:0]              gnt_idx;
   logic                          is_io;
   logic                          is_fb;

   function automatic logic [PTR_W-1:0] wrap_add(input int base, input int off);
      int sum;
      sum = base + off;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      return PTR_W'(sum);
   endfunction

   // First requester at or above rr_ptr, wrapping; a read+write request counts once.
   always_comb begin
      req       = cpu.dispatch_read | cpu.dispatch_write;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!gnt_valid && req[wrap_add(int'(rr_ptr_q), i)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = wrap_add(int'(rr_ptr_q), i);
         end
      end
   end

   assign is_io = (addr_q[ADDR_WIDTH-1:8] == IO_PREFIX);
   assign is_fb = !is_io && (addr_q[ADDR_WIDTH-1:16] == FB_PREFIX);

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_d       = grant_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      we_d          = we_q;
      cnt_d         = cnt_q;
      finished_op_d = '0;
      read_data_d   = read_data_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               grant_d  = gnt_idx;
               rr_ptr_d = wrap_add(int'(gnt_idx), 1);
               addr_d   = cpu.addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d  = cpu.write_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
               we_d     = cpu.dispatch_write[gnt_idx];
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (is_io) begin
               state_d = S_WAIT_IO;
            end else if (is_fb || we_q) begin
               // Frame buffer is write-only, so its reads complete with zero.
               if (!we_q) read_data_d[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = '0;
               finished_op_d[grant_q] = 1'b1;
               state_d                = S_DONE;
            end else begin
               cnt_d   = CNT_W'(RAM_LATENCY - 1);
               state_d = S_WAIT_RAM;
            end
         end
         S_WAIT_RAM: begin
            if (cnt_q == '0) begin
               read_data_d[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = ram_dout;
               finished_op_d[grant_q] = 1'b1;
               state_d                = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT_IO: begin
            if (io_ready) begin
               if (!we_q) read_data_d[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = io_rdata;
               finished_op_d[grant_q] = 1'b1;
               state_d                = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         we_q          <= 1'b0;
         cnt_q         <= '0;
         finished_op_q <= '0;
         read_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         we_q          <= we_d;
         cnt_q         <= cnt_d;
         finished_op_q <= finished_op_d;
         read_data_q   <= read_data_d;
      end
   end

   // Strobes decode from registered state only, so reset clears them immediately.
   assign ram_addr        = addr_q[15:0];
   assign ram_din         = wdata_q;
   assign ram_we          = (state_q == S_ISSUE) && !is_io && !is_fb && we_q;
   assign fb_write_addr   = addr_q[15:0];
   assign fb_write_data   = wdata_q;
   assign fb_write_enable = (state_q == S_ISSUE) && is_fb && we_q;
   assign io_addr         = addr_q[7:0];
   assign io_wdata        = wdata_q;
   assign io_we           = (state_q == S_WAIT_IO) && we_q;
   assign io_re           = (state_q == S_WAIT_IO) && !we_q;

   assign cpu.finished_op = finished_op_q;
   assign cpu.read_data   = read_data_q;
endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// Self-checking bench for multi_port_mem_ctrl: table-driven single accesses, a scoreboard
// of expected completions, and hand sequences for early drop, mid-op reset and round-robin.
module tb_multi_port_mem_ctrl;
   localparam int NP       = 4;
   localparam int AW       = 32;
   localparam int DW       = 8;
   localparam int RAM_LAT  = 2;
   localparam int IO_DELAY = 5;
   localparam int NV       = 13;

   typedef struct {
      int          port;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  wdata;
      logic        is_rd;
      logic [7:0]  rdata;
      int          lat;
      int          n_ram;
      int          n_fb;
      int          n_ior;
      int          n_iow;
      logic [15:0] saddr;
   } vec_t;

   typedef struct {
      int         port;
      logic       is_rd;
      logic [7:0] data;
   } sb_t;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic [15:0]   ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;
   logic [15:0]   fb_write_addr;
   logic [DW-1:0] fb_write_data;
   logic          fb_write_enable;
   logic [7:0]    io_addr;
   logic [DW-1:0] io_wdata;
   logic          io_we;
   logic          io_re;
   logic [DW-1:0] io_rdata;
   logic          io_ready = 1'b0;

   multi_port_mem_ctrl_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   multi_port_mem_ctrl #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(RAM_LAT)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .cpu(bus),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
      .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
      .fb_write_enable(fb_write_enable),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
      .io_rdata(io_rdata), .io_ready(io_ready)
   );

   always #5 clk_in = ~clk_in;

   // RAM with a fixed read pipeline of RAM_LAT cycles
   logic [7:0] mem [0:65535];
   logic [7:0] pipe [0:RAM_LAT-1];
   always @(posedge clk_in) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_dout = pipe[RAM_LAT-1];

   // IO device: raises io_ready after IO_DELAY cycles of io_re/io_we
   int io_cnt = 0;
   always @(posedge clk_in) begin
      if (io_re || io_we) begin
         io_cnt   <= io_cnt + 1;
         io_ready <= ((io_cnt + 1) == IO_DELAY);
      end else begin
         io_cnt   <= 0;
         io_ready <= 1'b0;
      end
   end

   int          checks = 0;
   int          errors = 0;
   int          n_done = 0;
   int          n_ram_we, n_fb_we, n_io_re, n_io_we;
   logic [15:0] strobe_addr;
   logic [7:0]  strobe_data;
   sb_t         sb_q[$];
   vec_t        vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int p, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [7:0] wd);
      bus.dispatch_read[p]         = rd;
      bus.dispatch_write[p]        = wr;
      bus.addr[p*AW +: AW]         = a;
      bus.write_data[p*DW +: DW]   = wd;
   endtask

   // One cycle: sample strobes and retire finished_op pulses against the scoreboard.
   task automatic tick();
      sb_t             e;
      logic [NP-1:0]   one;
      @(negedge clk_in);
      if (ram_we)          begin n_ram_we++; strobe_addr = ram_addr;        strobe_data = ram_din;       end
      if (fb_write_enable) begin n_fb_we++;  strobe_addr = fb_write_addr;   strobe_data = fb_write_data; end
      if (io_re)           begin n_io_re++;  strobe_addr = {8'h00, io_addr};                             end
      if (io_we)           begin n_io_we++;  strobe_addr = {8'h00, io_addr}; strobe_data = io_wdata;     end
      if (bus.finished_op != '0) begin
         n_done++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected finished_op=%0h expected none", bus.finished_op);
         end else begin
            e = sb_q.pop_front();
            one = '0;
            one[e.port] = 1'b1;
            check("sb_port", 32'(bus.finished_op), 32'(one));
            if (e.is_rd) check("sb_rdata", 32'(bus.read_data[e.port*DW +: DW]), 32'(e.data));
         end
      end
   endtask

   task automatic run_req(input vec_t v, input string tag, input bit drop_early);
      sb_t e;
      int  ticks;
      bit  got;
      n_ram_we = 0; n_fb_we = 0; n_io_re = 0; n_io_we = 0;
      strobe_addr = '0; strobe_data = '0;
      e.port = v.port; e.is_rd = v.is_rd; e.data = v.rdata;
      sb_q.push_back(e);
      drive(v.port, v.rd, v.wr, v.addr, v.wdata);
      ticks = 0;
      got   = 1'b0;
      while (!got && ticks < 40) begin
         tick();
         ticks++;
         if (drop_early && ticks == 1) drive(v.port, 1'b0, 1'b0, v.addr, v.wdata);
         if (bus.finished_op != '0) got = 1'b1;
      end
      drive(v.port, 1'b0, 1'b0, v.addr, v.wdata);
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s timeout after %0d cycles, no finished_op", tag, ticks);
         sb_q.delete();
      end else begin
         check({tag, "_latency"}, ticks + 1, v.lat);
         check({tag, "_ram_we"},  n_ram_we, v.n_ram);
         check({tag, "_fb_we"},   n_fb_we,  v.n_fb);
         check({tag, "_io_re"},   n_io_re,  v.n_ior);
         check({tag, "_io_we"},   n_io_we,  v.n_iow);
         if (v.n_ram + v.n_fb + v.n_ior + v.n_iow > 0) check({tag, "_strobe_addr"}, 32'(strobe_addr), 32'(v.saddr));
         if (v.n_ram + v.n_fb + v.n_iow > 0)           check({tag, "_strobe_data"}, 32'(strobe_data), 32'(v.wdata));
      end
      tick();
      check({tag, "_pulse_end"}, 32'(bus.finished_op), 32'h0);
   endtask

   function automatic vec_t mk(input int p, input logic rd, input logic wr, input logic [31:0] a,
                               input logic [7:0] wd, input logic is_rd, input logic [7:0] rdat,
                               input int lat, input int nr, input int nf, input int nir,
                               input int niw, input logic [15:0] sa);
      vec_t v;
      v.port = p; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
      v.is_rd = is_rd; v.rdata = rdat; v.lat = lat;
      v.n_ram = nr; v.n_fb = nf; v.n_ior = nir; v.n_iow = niw; v.saddr = sa;
      return v;
   endfunction

   initial begin
      vec_t v;
      sb_t  e;
      int   base;
      int   ticks;

      //            port rd wr addr          wd     isrd rdata lat ram fb ior iow strobe-addr
      vecs[0]  = mk(0, 0, 1, 32'h0001_0010, 8'hA5, 0, 8'h00, 3, 1, 0, 0, 0, 16'h0010);
      vecs[1]  = mk(0, 1, 0, 32'h0001_0010, 8'h00, 1, 8'hA5, 5, 0, 0, 0, 0, 16'h0000);
      vecs[2]  = mk(1, 0, 1, 32'h0000_1234, 8'h3C, 0, 8'h00, 3, 0, 1, 0, 0, 16'h1234);
      vecs[3]  = mk(1, 1, 0, 32'h0001_0010, 8'h00, 1, 8'hA5, 5, 0, 0, 0, 0, 16'h0000);
      vecs[4]  = mk(1, 1, 0, 32'h0000_1234, 8'h00, 1, 8'h00, 3, 0, 0, 0, 0, 16'h0000);
      vecs[5]  = mk(2, 1, 0, 32'hFFFF_FF04, 8'h00, 1, 8'h5A, 9, 0, 0, 6, 0, 16'h0004);
      vecs[6]  = mk(3, 1, 1, 32'h0002_0044, 8'h77, 0, 8'h00, 3, 1, 0, 0, 0, 16'h0044);
      vecs[7]  = mk(3, 1, 0, 32'h0002_0044, 8'h00, 1, 8'h77, 5, 0, 0, 0, 0, 16'h0000);
      vecs[8]  = mk(2, 0, 1, 32'hFFFF_FF10, 8'h99, 0, 8'h00, 9, 0, 0, 0, 6, 16'h0010);
      vecs[9]  = mk(0, 0, 1, 32'h1234_ABCD, 8'h11, 0, 8'h00, 3, 1, 0, 0, 0, 16'hABCD);
      vecs[10] = mk(3, 1, 0, 32'h0005_ABCD, 8'h00, 1, 8'h11, 5, 0, 0, 0, 0, 16'h0000);
      vecs[11] = mk(1, 0, 1, 32'hFFFF_FE00, 8'h42, 0, 8'h00, 3, 1, 0, 0, 0, 16'hFE00);
      vecs[12] = mk(0, 0, 1, 32'h0000_FFFF, 8'hE7, 0, 8'h00, 3, 0, 1, 0, 0, 16'hFFFF);

      io_rdata           = 8'h5A;
      rst_in             = 1'b0;
      bus.dispatch_read  = '0;
      bus.dispatch_write = '0;
      bus.addr           = '0;
      bus.write_data     = '0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_finished_op", 32'(bus.finished_op), 32'h0);
      check("rst_read_data",   32'(bus.read_data),   32'h0);
      check("rst_strobes", {28'h0, ram_we, fb_write_enable, io_we, io_re}, 32'h0);
      rst_in = 1'b1;

      for (int i = 0; i < NV; i++) run_req(vecs[i], $sformatf("vec%0d", i), 1'b0);
      check("slot2_hold_after_io_write", 32'(bus.read_data[2*DW +: DW]), 32'h5A);

      // Requests dropped after the grant still complete.
      v = mk(0, 0, 1, 32'h0001_0020, 8'h5E, 0, 8'h00, 3, 1, 0, 0, 0, 16'h0020);
      run_req(v, "drop_wr", 1'b1);
      v = mk(0, 1, 0, 32'h0001_0020, 8'h00, 1, 8'h5E, 5, 0, 0, 0, 0, 16'h0000);
      run_req(v, "drop_rd", 1'b1);

      // Reset while a RAM read sits in WAIT_RAM.
      drive(1, 1'b1, 1'b0, 32'h0001_0010, 8'h00);
      tick();
      tick();
      #2 rst_in = 1'b0;
      #1;
      check("midrst_finished_op", 32'(bus.finished_op), 32'h0);
      check("midrst_read_data",   32'(bus.read_data),   32'h0);
      check("midrst_strobes", {28'h0, ram_we, fb_write_enable, io_we, io_re}, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0001_0010, 8'h00);
      @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      base = n_done;
      repeat (4) tick();
      check("midrst_no_finish", n_done - base, 0);

      // All four ports request continuously; rr_ptr restarts at 0 after reset.
      for (int p = 0; p < NP; p++) begin
         e.port = p; e.is_rd = 1'b0; e.data = 8'h00;
         sb_q.push_back(e);
      end
      e.port = 0;
      sb_q.push_back(e);
      for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b1, 32'h0003_0000 + 32'(p), 8'h10 + 8'(p));
      base  = n_done;
      ticks = 0;
      while ((n_done - base) < 5 && ticks < 60) begin
         tick();
         ticks++;
      end
      for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, 32'h0003_0000 + 32'(p), 8'h10 + 8'(p));
      check("rr_done_count", n_done - base, 5);
      check("rr_cycles", ticks, 14);
      tick();
      check("rr_pulse_end", 32'(bus.finished_op), 32'h0);
      check("rr_sb_empty", sb_q.size(), 0);
      sb_q.delete();

      v = mk(1, 1, 0, 32'h0001_0010, 8'h00, 1, 8'hA5, 5, 0, 0, 0, 0, 16'h0000);
      run_req(v, "post_rst_rd", 1'b0);
      v = mk(2, 1, 0, 32'h0003_0002, 8'h00, 1, 8'h12, 5, 0, 0, 0, 0, 16'h0000);
      run_req(v, "rr_data_rd", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
